bf_uart_tx: RTL and testbench

- Output stage directly downstream of brainfuckCore: consumes the core's one-cycle character strobe and byte (the "." instruction output).
- Buffers characters in a small FIFO and serialises them on a UART TX line, 8N1, LSB first.
- Decouples the core's burst output from the slow serial line; reports overflow because the core has no stall input.

---
 rtl/bf_uart_tx.sv | 178 +++++++++++++++++
 tb/tb_bf_uart_tx.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bf_uart_tx.sv
// UART 8N1 transmitter with a character FIFO, fed by the brainfuck core's output strobe.
// Drops pushes into a full FIFO and latches a sticky overflow flag, since the core cannot stall.
module bf_uart_tx #(
    parameter int unsigned CLK_PER_BIT = 16,
    parameter int unsigned FIFO_AW     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             char_valid,
    input  logic [7:0]       char_data,
    output logic             tx,
    output logic             busy,
    output logic             fifo_empty,
    output logic             fifo_full,
    output logic [FIFO_AW:0] fifo_count,
    output logic             overflow
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned CNT_W = $clog2(CLK_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [FIFO_AW:0] CNT_FULL = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               empty_q, empty_d;
    logic               full_q, full_d;
    logic               overflow_q, overflow_d;
    logic [7:0]         mem_q [DEPTH];

    logic pop_c;
    logic push_c;
    logic bit_last_c;

    // Framing FSM plus FIFO bookkeeping; a pop always loads the head into the shifter.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        pop_c      = 1'b0;
        bit_last_c = (bit_cnt_q == CNT_LAST);

        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (count_q != '0) begin
                    pop_c     = 1'b1;
                    shift_d   = mem_q[rd_ptr_q];
                    state_d   = ST_START;
                    tx_d      = 1'b0;
                    bit_cnt_d = '0;
                end
            end
            ST_START: begin
                if (bit_last_c) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (bit_last_c) begin
                    bit_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[1];
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (bit_last_c) begin
                    bit_cnt_d = '0;
                    // Back-to-back frames: skip IDLE when more data is waiting.
                    if (count_q != '0) begin
                        pop_c   = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        state_d = ST_START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        push_c     = char_valid && ((count_q != CNT_FULL) || pop_c);
        overflow_d = overflow_q | (char_valid & ~push_c);
        wr_ptr_d   = push_c ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop_c  ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;

        case ({push_c, pop_c})
            2'b10:   count_d = count_q + (FIFO_AW + 1)'(1);
            2'b01:   count_d = count_q - (FIFO_AW + 1)'(1);
            default: count_d = count_q;
        endcase

        empty_d = (count_d == '0);
        full_d  = (count_d == CNT_FULL);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_c && !reset) begin
            mem_q[wr_ptr_q] <= char_data;
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign fifo_empty = empty_q;
    assign fifo_full  = full_q;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_bf_uart_tx.sv
// Directed bench for bf_uart_tx: a serial-line monitor decodes frames, the main sequence checks them.
module tb_bf_uart_tx;

    localparam int unsigned CPB = 4;
    localparam int unsigned AW  = 4;
    localparam int unsigned FRAME = 10 * CPB;
    localparam int unsigned MID = CPB / 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          char_valid;
    logic [7:0]    char_data;
    logic          tx;
    logic          busy;
    logic          fifo_empty;
    logic          fifo_full;
    logic [AW:0]   fifo_count;
    logic          overflow;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int rst_cnt = 0;
    int framing_err = 0;

    logic [7:0] rx_q [$];
    int         st_q [$];

    bf_uart_tx #(.CLK_PER_BIT(CPB), .FIFO_AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .char_valid (char_valid),
        .char_data  (char_data),
        .tx         (tx),
        .busy       (busy),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) rst_cnt <= rst_cnt + 1;
    end

    // Line decoder: samples mid-bit, discards frames that a reset cut short.
    logic [7:0] m_byte;
    int         m_st;
    int         m_rst;
    logic       m_ok;
    initial begin
        forever begin
            @(posedge clk); #2;
            if (tx === 1'b0) begin
                m_st  = cyc;
                m_rst = rst_cnt;
                m_ok  = 1'b1;
                repeat (MID) begin @(posedge clk); #2; end
                if (tx !== 1'b0) m_ok = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) begin @(posedge clk); #2; end
                    m_byte[i] = tx;
                end
                repeat (CPB) begin @(posedge clk); #2; end
                if (tx !== 1'b1) m_ok = 1'b0;
                repeat (CPB - 1 - MID) begin @(posedge clk); #2; end
                if (m_rst == rst_cnt) begin
                    if (!m_ok) framing_err = framing_err + 1;
                    rx_q.push_back(m_byte);
                    st_q.push_back(m_st);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic push(input logic [7:0] b);
        char_valid = 1'b1;
        char_data  = b;
        tick;
        char_valid = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget);
        int k;
        k = 0;
        while (rx_q.size() < n && k < budget) begin
            tick;
            k++;
        end
        chk("wait_frames", rx_q.size(), n);
    endtask

    function automatic logic [7:0] rx_get(input int i);
        return (i < rx_q.size()) ? rx_q[i] : 8'hxx;
    endfunction

    function automatic int st_get(input int i);
        return (i < st_q.size()) ? st_q[i] : -1;
    endfunction

    int base;
    int t0;
    int zeros;
    int busy_hits;

    initial begin
        reset      = 1'b1;
        char_valid = 1'b1;
        char_data  = 8'h55;

        // Reset held with a strobe active: nothing may be pushed.
        repeat (3) tick;
        reset      = 1'b0;
        char_valid = 1'b0;
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_empty", fifo_empty, 1);
        chk("rst_full", fifo_full, 0);
        tick;
        chk("rst_nopush_count", fifo_count, 0);
        chk("rst_nopush_busy", busy, 0);

        // Single character 0x41.
        base = rx_q.size();
        push(8'h41);
        chk("single_count_after_push", fifo_count, 1);
        chk("single_tx_before_start", tx, 1);
        chk("single_busy_before_start", busy, 0);
        tick;
        chk("single_start_tx", tx, 0);
        chk("single_start_busy", busy, 1);
        chk("single_count_popped", fifo_count, 0);
        repeat (FRAME - 1) tick;
        chk("single_busy_last_stop", busy, 1);
        chk("single_tx_last_stop", tx, 1);
        tick;
        chk("single_busy_done", busy, 0);
        chk("single_empty_done", fifo_empty, 1);
        chk("single_tx_idle", tx, 1);
        chk("single_frames", rx_q.size() - base, 1);
        chk("single_byte", rx_get(base), 8'h41);

        // Three back-to-back characters.
        base = rx_q.size();
        push(8'h48);
        t0 = cyc;
        chk("b2b_count1", fifo_count, 1);
        push(8'h69);
        chk("b2b_count2", fifo_count, 1);
        push(8'h0A);
        chk("b2b_count_peak", fifo_count, 2);
        wait_rx(base + 3, 3 * FRAME + 50);
        chk("b2b_byte0", rx_get(base), 8'h48);
        chk("b2b_byte1", rx_get(base + 1), 8'h69);
        chk("b2b_byte2", rx_get(base + 2), 8'h0A);
        chk("b2b_first_start", st_get(base), t0 + 1);
        chk("b2b_gap01", st_get(base + 1) - st_get(base), FRAME);
        chk("b2b_gap12", st_get(base + 2) - st_get(base + 1), FRAME);
        chk("b2b_busy_done", busy, 0);
        chk("b2b_empty_done", fifo_empty, 1);

        // Overflow: 18 consecutive pushes, the last one dropped.
        base = rx_q.size();
        for (int i = 0; i < 17; i++) push(8'h10 + 8'(i));
        chk("ovf_full_count", fifo_count, 16);
        chk("ovf_full_flag", fifo_full, 1);
        chk("ovf_not_yet", overflow, 0);
        push(8'h21);
        chk("ovf_set", overflow, 1);
        chk("ovf_count_kept", fifo_count, 16);
        wait_rx(base + 17, 17 * FRAME + 100);
        for (int i = 0; i < 17; i++) chk($sformatf("ovf_byte%0d", i), rx_get(base + i), 8'h10 + 8'(i));
        chk("ovf_sticky", overflow, 1);
        chk("ovf_drained", fifo_empty, 1);
        repeat (60) tick;
        chk("ovf_no_extra", rx_q.size() - base, 17);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("ovf_cleared_by_reset", overflow, 0);

        // Push on the last stop cycle while full: accepted via the simultaneous pop.
        base = rx_q.size();
        push(8'h30);
        t0 = cyc;
        for (int i = 1; i < 17; i++) push(8'h30 + 8'(i));
        chk("fp_count_full", fifo_count, 16);
        repeat (t0 + FRAME - cyc) tick;
        chk("fp_busy_stop", busy, 1);
        chk("fp_tx_stop", tx, 1);
        push(8'hEE);
        chk("fp_count_kept", fifo_count, 16);
        chk("fp_full_kept", fifo_full, 1);
        chk("fp_no_overflow", overflow, 0);
        chk("fp_next_start", tx, 0);
        wait_rx(base + 18, 18 * FRAME + 100);
        chk("fp_first", rx_get(base), 8'h30);
        chk("fp_seventeenth", rx_get(base + 16), 8'h40);
        chk("fp_last", rx_get(base + 17), 8'hEE);
        chk("fp_overflow_end", overflow, 0);

        // Reset during DATA with three bytes queued.
        base = rx_q.size();
        push(8'hA1);
        push(8'hA2);
        push(8'hA3);
        push(8'hA4);
        chk("mr_count_queued", fifo_count, 3);
        repeat (13) tick;
        chk("mr_busy_before", busy, 1);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("mr_tx", tx, 1);
        chk("mr_count", fifo_count, 0);
        chk("mr_busy", busy, 0);
        chk("mr_empty", fifo_empty, 1);
        zeros     = 0;
        busy_hits = 0;
        repeat (200) begin
            tick;
            if (tx !== 1'b1) zeros++;
            if (busy !== 1'b0) busy_hits++;
        end
        chk("mr_line_quiet", zeros, 0);
        chk("mr_never_busy", busy_hits, 0);
        chk("mr_no_frames", rx_q.size() - base, 0);
        chk("framing_errors", framing_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
